// File: rtl/dvp_frame_source_pkg.sv
// Shared definitions for the DVP test-pattern transmitter: FSM states,
// pattern codes, colour-bar palette and CRC-16-CCITT constants.
package dvp_frame_source_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFP
  } state_t;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_COUNT = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // MSB-first CRC-16-CCITT, one byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dvp_frame_source_pattern_gen.sv
// Registered test-pattern byte generator; loads a new byte on each pclk tick
// and drives zero whenever the transmitter is outside an active line.
module dvp_frame_source_pattern_gen
  import dvp_frame_source_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        active,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        phase,
  input  logic [1:0]  sel,
  input  logic [15:0] solid,
  input  logic [7:0]  cnt,
  output logic [7:0]  data_o
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [7:0]  data_q, data_d;
  logic [15:0] pix;
  logic [9:0]  bar_idx;
  logic        unused_bits;

  assign bar_idx     = x / 10'(BAR_W);
  assign unused_bits = ^{y, bar_idx[9:3]};

  always_comb begin
    pix = solid;
    case (sel)
      PAT_BARS:  pix = bar_color(bar_idx[2:0]);
      PAT_RAMP:  pix = {x[9:5], x[9:4], x[9:5]};
      PAT_COUNT: pix = {cnt, cnt};
      default:   pix = solid;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = active ? (phase ? pix[7:0] : pix[15:8]) : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/dvp_frame_source.sv
// DVP camera-side frame transmitter producing test-pattern frames.
// Optional macro DVP_SRC_CRC_EN adds frame_crc (CRC-16-CCITT of active bytes).
module dvp_frame_source
  import dvp_frame_source_pkg::*;
#(
  parameter int PCLK_HALF   = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 17,
  parameter int V_FP        = 10
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        pclk_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  data_o,
  output logic        frame_done,
  output logic [15:0] frame_count
`ifdef DVP_SRC_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam int L         = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_LINES = (VSYNC_LINES > V_BP) ?
                             ((VSYNC_LINES > V_FP) ? VSYNC_LINES : V_FP) :
                             ((V_BP > V_FP) ? V_BP : V_FP);
  localparam int CW        = $clog2(MAX_LINES * L + 1);
  localparam int DW        = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PCLK_HALF - 1);
  localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_LINES * L - 1);
  localparam logic [CW-1:0] VBP_LAST = CW'(V_BP * L - 1);
  localparam logic [CW-1:0] VFP_LAST = CW'(V_FP * L - 1);
  localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
  localparam logic [9:0]    X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [8:0]    Y_LAST   = 9'(V_ACTIVE - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic            pclk_q, pclk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic            phase_q, phase_d;
  logic [7:0]      bcnt_q, bcnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [15:0]     solid_q, solid_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic            done_q, done_d;
  logic [15:0]     fcount_q, fcount_d;
  logic            tick;
  logic            start;

  // pclk falls in the cycle of a tick; all line/frame state moves only then
  assign tick   = pclk_q && (div_q == DIV_LAST);
  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  assign pclk_d = (div_q == DIV_LAST) ? ~pclk_q : pclk_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    phase_d  = phase_q;
    bcnt_d   = bcnt_q;
    sel_d    = sel_q;
    solid_d  = solid_q;
    done_d   = 1'b0;
    fcount_d = fcount_q;
    start    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) start = 1'b1;
        end
        ST_VSYNC: begin
          if (cnt_q == VS_LAST) begin
            cnt_d   = '0;
            state_d = ST_VBP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_VBP: begin
          if (cnt_q == VBP_LAST) begin
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
            state_d = ST_ACTIVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ACTIVE: begin
          bcnt_d = bcnt_q + 1'b1;
          if (x_q == X_LAST && phase_q) begin
            cnt_d   = '0;
            state_d = ST_HBLANK;
          end else begin
            phase_d = ~phase_q;
            if (phase_q) x_d = x_q + 1'b1;
          end
        end
        ST_HBLANK: begin
          if (cnt_q == HB_LAST) begin
            cnt_d = '0;
            if (y_q == Y_LAST) begin
              state_d = ST_VFP;
            end else begin
              y_d     = y_q + 1'b1;
              x_d     = '0;
              phase_d = 1'b0;
              state_d = ST_ACTIVE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_VFP: begin
          if (cnt_q == VFP_LAST) begin
            cnt_d    = '0;
            done_d   = 1'b1;
            fcount_d = fcount_q + 1'b1;
            state_d  = ST_IDLE;
            if (enable) start = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (start) begin
        state_d = ST_VSYNC;
        cnt_d   = '0;
        bcnt_d  = '0;
        sel_d   = pattern_sel;
        solid_d = solid_color;
      end
    end
  end

  assign vsync_d = tick ? (state_d == ST_VSYNC)  : vsync_q;
  assign href_d  = tick ? (state_d == ST_ACTIVE) : href_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      pclk_q   <= 1'b0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      phase_q  <= 1'b0;
      bcnt_q   <= '0;
      sel_q    <= '0;
      solid_q  <= '0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      done_q   <= 1'b0;
      fcount_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      pclk_q   <= pclk_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      phase_q  <= phase_d;
      bcnt_q   <= bcnt_d;
      sel_q    <= sel_d;
      solid_q  <= solid_d;
      vsync_q  <= vsync_d;
      href_q   <= href_d;
      done_q   <= done_d;
      fcount_q <= fcount_d;
    end
  end

  // Generator is fed the position of the byte that becomes visible after this tick
  dvp_frame_source_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern_gen (
    .clk    (sys_clk),
    .rst    (rst),
    .en     (tick),
    .active (state_d == ST_ACTIVE),
    .x      (x_d),
    .y      (y_d),
    .phase  (phase_d),
    .sel    (sel_q),
    .solid  (solid_q),
    .cnt    (bcnt_d),
    .data_o (data_o)
  );

`ifdef DVP_SRC_CRC_EN
  logic [15:0] crc_run_q, crc_run_d;
  logic [15:0] crc_out_q, crc_out_d;

  always_comb begin
    crc_run_d = crc_run_q;
    if (tick && state_q == ST_ACTIVE) crc_run_d = crc16_byte(crc_run_q, data_o);
    if (start) crc_run_d = CRC_INIT;
    crc_out_d = done_d ? crc_run_q : crc_out_q;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      crc_run_q <= CRC_INIT;
      crc_out_q <= CRC_INIT;
    end else begin
      crc_run_q <= crc_run_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign frame_crc = crc_out_q;
`endif

  assign pclk_o      = pclk_q;
  assign vsync_o     = vsync_q;
  assign href_o      = href_q;
  assign frame_done  = done_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_dvp_frame_source.sv
// Bench for dvp_frame_source with a small frame geometry; expected pixel
// stream is computed from frame-relative tick index in a reference model.
module tb_dvp_frame_source;

  localparam int HA = 8, VA = 2, HB = 4, VSL = 1, VBPL = 1, VFPL = 1, PH = 1;
  localparam int L       = 2 * HA + HB;
  localparam int T_VS    = VSL * L;
  localparam int T_VBP   = VBPL * L;
  localparam int T_ACT   = VA * L;
  localparam int T_FRAME = T_VS + T_VBP + T_ACT + VFPL * L;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic        pclk_o, vsync_o, href_o, frame_done;
  logic [7:0]  data_o;
  logic [15:0] frame_count;
`ifdef DVP_SRC_CRC_EN
  logic [15:0] frame_crc;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always #5 sys_clk = ~sys_clk;

  dvp_frame_source #(
    .PCLK_HALF(PH), .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VSL), .V_BP(VBPL), .V_FP(VFPL)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_color (solid_color),
    .pclk_o      (pclk_o),
    .vsync_o     (vsync_o),
    .href_o      (href_o),
    .data_o      (data_o),
    .frame_done  (frame_done),
    .frame_count (frame_count)
`ifdef DVP_SRC_CRC_EN
    ,
    .frame_crc   (frame_crc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the sample point just after the next falling pclk edge
  task automatic next_tick();
    logic p;
    bit   found;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      p = pclk_o;
      @(posedge sys_clk);
      #1;
      if (p && !pclk_o) found = 1;
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL pclk_tick observed=no_fall expected=fall_within_8_cycles");
    end
  endtask

  // Expected {vsync, href, data} at frame-relative tick t
  function automatic logic [9:0] model(input int t, input logic [1:0] sel, input logic [15:0] solid);
    int r, line, c, x;
    logic [9:0]  xv;
    logic [15:0] pix;
    if (t < T_VS) return {1'b1, 1'b0, 8'h00};
    if (t < T_VS + T_VBP || t >= T_VS + T_VBP + T_ACT) return 10'h000;
    r    = t - T_VS - T_VBP;
    line = r / L;
    c    = r % L;
    if (c >= 2 * HA) return 10'h000;
    x  = c / 2;
    xv = 10'(x);
    case (sel)
      2'd0:    pix = bars[x / (HA / 8)];
      2'd1:    pix = {xv[9:5], xv[9:4], xv[9:5]};
      2'd2:    return {2'b01, 8'(line * 2 * HA + c)};
      default: pix = solid;
    endcase
    return {2'b01, (c % 2 == 1) ? pix[7:0] : pix[15:8]};
  endfunction

  function automatic logic [15:0] crc_ref(input int nbytes, input logic [7:0] val);
    logic [15:0] crc;
    logic        fb;
    crc = 16'hFFFF;
    for (int n = 0; n < nbytes; n++) begin
      for (int b = 7; b >= 0; b--) begin
        fb  = crc[15] ^ val[b];
        crc = {crc[14:0], 1'b0};
        if (fb) crc = crc ^ 16'h1021;
      end
    end
    return crc;
  endfunction

  task automatic check_sample(input int t, input logic [1:0] sel, input logic [15:0] solid);
    logic [9:0] e;
    e = model(t, sel, solid);
    check($sformatf("vsync t=%0d", t), vsync_o, e[9]);
    check($sformatf("href t=%0d", t), href_o, e[8]);
    check($sformatf("data t=%0d", t), data_o, e[7:0]);
  endtask

  // Current sample must already be tick 0 of the frame; ends on the tick after the front porch
  task automatic run_frame(input int chg_t, input logic [1:0] n_sel, input logic [15:0] n_solid,
                           input logic n_en, input int exp_count);
    logic [1:0]  fsel;
    logic [15:0] fsolid;
    fsel   = pattern_sel;
    fsolid = solid_color;
    for (int t = 0; t <= T_FRAME; t++) begin
      if (t > 0) next_tick();
      if (t < T_FRAME) begin
        check_sample(t, fsel, fsolid);
        if (t > 0) check($sformatf("frame_done_low t=%0d", t), frame_done, 1'b0);
      end else begin
        check("frame_done_pulse", frame_done, 1'b1);
        check("frame_count", frame_count, 32'(exp_count));
      end
      if (t == chg_t) begin
        pattern_sel = n_sel;
        solid_color = n_solid;
        enable      = n_en;
      end
    end
  endtask

  task automatic idle_ticks(input int n, input int exp_count);
    for (int i = 0; i < n; i++) begin
      next_tick();
      check("idle_vsync", vsync_o, 1'b0);
      check("idle_href", href_o, 1'b0);
      check("idle_data", data_o, 8'h00);
      check("idle_count", frame_count, 32'(exp_count));
    end
  endtask

  logic [1:0]  rsel;
  logic [15:0] rsolid;

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    solid_color = 16'h0000;
    rsel   = 2'($urandom_range(0, 3));
    rsolid = 16'($urandom);

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_pclk", pclk_o, 1'b0);
    check("rst_vsync", vsync_o, 1'b0);
    check("rst_href", href_o, 1'b0);
    check("rst_data", data_o, 8'h00);
    check("rst_done", frame_done, 1'b0);
    check("rst_count", frame_count, 16'h0000);
`ifdef DVP_SRC_CRC_EN
    check("rst_crc", frame_crc, 16'hFFFF);
`endif

    @(negedge sys_clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk);
      #1;
      check($sformatf("pclk_phase %0d", i), pclk_o, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    idle_ticks(2, 0);

    // Bars, with a mid-frame switch to solid that must wait for the next frame
    enable = 1'b1;
    pattern_sel = 2'd0;
    next_tick();
    run_frame(50, 2'd3, 16'hABCD, 1'b1, 1);
    run_frame(10, 2'd2, 16'hABCD, 1'b1, 2);
    run_frame(-1, 2'd2, 16'hABCD, 1'b1, 3);
    run_frame(60, rsel, rsolid, 1'b1, 4);
    // Enable dropped during line 0: the frame still completes
    run_frame(T_VS + T_VBP + 1, rsel, rsolid, 1'b0, 5);
    check("post_frame_vsync", vsync_o, 1'b0);
    check("post_frame_href", href_o, 1'b0);
    idle_ticks(4, 5);

    // Reset pulse in the middle of an active line
    enable = 1'b1;
    pattern_sel = 2'd1;
    next_tick();
    for (int t = 0; t <= T_VS + T_VBP + 5; t++) begin
      if (t > 0) next_tick();
      check_sample(t, 2'd1, solid_color);
    end
    check("pre_rst_href", href_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_href", href_o, 1'b0);
    check("mid_rst_vsync", vsync_o, 1'b0);
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_pclk", pclk_o, 1'b0);
    check("mid_rst_count", frame_count, 16'h0000);
    pattern_sel = 2'd3;
    solid_color = 16'h0000;
    @(negedge sys_clk);
    rst = 1'b0;
    next_tick();
    run_frame(T_VS + T_VBP + 1, 2'd3, 16'h0000, 1'b0, 1);
`ifdef DVP_SRC_CRC_EN
    check("frame_crc_zero", frame_crc, crc_ref(2 * HA * VA, 8'h00));
`endif
    idle_ticks(2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
